mem_stage_hs: RTL and testbench

Next-generation MEM pipeline stage for the 5-stage MIPS core, placed between EX and WB. It replaces the fixed single-cycle SRAM access with a req/gnt/rvalid handshake data-memory port that tolerates variable latency. The stage aligns load and store data itself, detects misaligned accesses, and bounds each access with a timeout. It requests a pipeline stall while an access is outstanding.

---
 rtl/mem_pkg.sv | 43 ++++
 rtl/mem_align.sv | 80 ++++++++
 rtl/mem_stage_hs.sv | 187 ++++++++++++++++++
 tb/tb_mem_stage_hs.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and constants for the MEM pipeline stage.
package mem_pkg;

    // Memory operation codes carried from EX.
    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_LB   = 3'd1,
        OP_LBU  = 3'd2,
        OP_LH   = 3'd3,
        OP_LHU  = 3'd4,
        OP_LW   = 3'd5,
        OP_ST   = 3'd6
    } mem_op_e;

    // Store access size; 3 is unused and treated as a word.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } st_size_e;

    // Data-port access FSM.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } mem_state_e;

    localparam int STALL_MEM    = 3;
    localparam int STALL_WB     = 4;
    localparam int MEM_TO_WB_WD = 70;
    localparam int MEM_TO_RF_WD = 38;

    function automatic logic is_load_op(input logic [2:0] op);
        return (op >= OP_LB) && (op <= OP_LW);
    endfunction

    function automatic logic is_mem_op(input logic [2:0] op);
        return (op >= OP_LB) && (op <= OP_ST);
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane alignment for the MEM stage: store strobes and replicated store
// data, load lane select with sign/zero extension, and misalignment check.
module mem_align
    import mem_pkg::*;
(
    input  logic [2:0]  mem_op,
    input  logic [1:0]  st_size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wen,
    output logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic        misaligned
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store strobes and lane-replicated store data.
    always_comb begin
        wen   = 4'b0000;
        wdata = 32'h0;
        if (mem_op == OP_ST) begin
            case (st_size)
                SZ_BYTE: begin
                    wen   = 4'b0001 << addr_lo;
                    wdata = {4{st_data[7:0]}};
                end
                SZ_HALF: begin
                    wen   = 4'b0011 << {addr_lo[1], 1'b0};
                    wdata = {2{st_data[15:0]}};
                end
                default: begin
                    wen   = 4'b1111;
                    wdata = st_data;
                end
            endcase
        end
    end

    // Little-endian lane select and extension of the captured read data.
    always_comb begin
        ld_byte  = 8'h0;
        load_val = 32'h0;
        case (addr_lo)
            2'd0:    ld_byte = rdata[7:0];
            2'd1:    ld_byte = rdata[15:8];
            2'd2:    ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
        ld_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (mem_op)
            OP_LB:   load_val = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  load_val = {24'h0, ld_byte};
            OP_LH:   load_val = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  load_val = {16'h0, ld_half};
            OP_LW:   load_val = rdata;
            default: load_val = 32'h0;
        endcase
    end

    // Halfword needs addr[0]==0, word needs addr[1:0]==0.
    always_comb begin
        misaligned = 1'b0;
        case (mem_op)
            OP_LH, OP_LHU: misaligned = addr_lo[0];
            OP_LW:         misaligned = (addr_lo != 2'b00);
            OP_ST: begin
                case (st_size)
                    SZ_BYTE: misaligned = 1'b0;
                    SZ_HALF: misaligned = addr_lo[0];
                    default: misaligned = (addr_lo != 2'b00);
                endcase
            end
            default:       misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_stage_hs.sv
// MEM pipeline stage with a req/gnt/rvalid data-memory port, in-stage
// alignment, misalignment detection and a bounded wait for read data.
//
// Handshake: data_req is a request-valid; the address/strobe/data bundle is
// held stable from the first cycle data_req is high until the cycle data_gnt
// is sampled high, which accepts it. A load then completes on the first cycle
// data_rvalid is high (which may be the grant cycle itself); stores complete
// at grant. rvalid has no ready: it is consumed or dropped the cycle it appears.
module mem_stage_hs
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = $clog2(TIMEOUT + 1),
    parameter int STALL_W = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_W-1:0]      stall,
    input  logic [31:0]             ex_pc,
    input  logic [2:0]              ex_mem_op,
    input  logic [1:0]              ex_st_size,
    input  logic [ADDR_W-1:0]       ex_addr,
    input  logic [31:0]             ex_st_data,
    input  logic                    ex_rf_we,
    input  logic [4:0]              ex_rf_waddr,
    input  logic [31:0]             ex_result,
    output logic                    data_req,
    output logic                    data_we,
    output logic [ADDR_W-1:0]       data_addr,
    output logic [3:0]              data_wen,
    output logic [31:0]             data_wdata,
    input  logic                    data_gnt,
    input  logic                    data_rvalid,
    input  logic [31:0]             data_rdata,
    output logic                    stallreq_for_mem,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus,
    output logic [1:0]              mem_excp,
    output logic [1:0]              dbg_state
);

    // Input register contents.
    logic [31:0]       pc_r;
    logic [2:0]        op_r;
    logic [1:0]        sz_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       st_data_r;
    logic              rf_we_r;
    logic [4:0]        waddr_r;
    logic [31:0]       result_r;

    // Access tracking.
    mem_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic              done_r;
    logic              tmo_r;
    logic [31:0]       rdata_r;

    logic ld_bubble, ld_ex, ld_any;
    logic is_mem, is_store, is_load, pending, mis;
    logic [3:0]  al_wen;
    logic [31:0] al_wdata, al_load_val;
    logic        rf_we_out;
    logic [31:0] rf_wdata;

    assign ld_bubble = stall[STALL_MEM] & ~stall[STALL_WB];
    assign ld_ex     = ~stall[STALL_MEM];
    assign ld_any    = ld_bubble | ld_ex;

    // Input register: bubble, load from EX, or hold.
    always_ff @(posedge clk) begin
        if (rst || ld_bubble) begin
            pc_r      <= 32'h0;
            op_r      <= OP_NONE;
            sz_r      <= 2'b00;
            addr_r    <= '0;
            st_data_r <= 32'h0;
            rf_we_r   <= 1'b0;
            waddr_r   <= 5'h0;
            result_r  <= 32'h0;
        end else if (ld_ex) begin
            pc_r      <= ex_pc;
            op_r      <= ex_mem_op;
            sz_r      <= ex_st_size;
            addr_r    <= ex_addr;
            st_data_r <= ex_st_data;
            rf_we_r   <= ex_rf_we;
            waddr_r   <= ex_rf_waddr;
            result_r  <= ex_result;
        end
    end

    mem_align u_align (
        .mem_op     (op_r),
        .st_size    (sz_r),
        .addr_lo    (addr_r[1:0]),
        .st_data    (st_data_r),
        .rdata      (rdata_r),
        .wen        (al_wen),
        .wdata      (al_wdata),
        .load_val   (al_load_val),
        .misaligned (mis)
    );

    assign is_mem   = is_mem_op(op_r);
    assign is_store = (op_r == OP_ST);
    assign is_load  = is_load_op(op_r);
    assign pending  = is_mem & ~done_r;

    // Access FSM: issue, wait for grant, wait for data or timeout, then hold
    // the result until the pipeline moves a new instruction into MEM. A load
    // into the input register always restarts the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            done_r  <= 1'b0;
            tmo_r   <= 1'b0;
            rdata_r <= 32'h0;
        end else if (ld_any) begin
            state  <= S_IDLE;
            cnt    <= '0;
            done_r <= 1'b0;
            tmo_r  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_REQ: begin
                    if (pending) begin
                        if (mis) begin
                            done_r <= 1'b1;
                        end else if (data_gnt) begin
                            if (is_store) begin
                                state  <= S_DONE;
                                done_r <= 1'b1;
                            end else if (data_rvalid) begin
                                rdata_r <= data_rdata;
                                state   <= S_DONE;
                                done_r  <= 1'b1;
                            end else begin
                                state <= S_WAIT;
                                cnt   <= '0;
                            end
                        end else begin
                            state <= S_REQ;
                        end
                    end
                end
                S_WAIT: begin
                    if (data_rvalid) begin
                        rdata_r <= data_rdata;
                        state   <= S_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(TIMEOUT - 1)) begin
                            tmo_r  <= 1'b1;
                            state  <= S_DONE;
                            done_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_DONE;
                end
            endcase
        end
    end

    assign data_req   = pending & ~mis & ((state == S_IDLE) | (state == S_REQ));
    assign data_we    = is_store;
    assign data_addr  = {addr_r[ADDR_W-1:2], 2'b00};
    assign data_wen   = al_wen;
    assign data_wdata = al_wdata;

    assign stallreq_for_mem = pending & (state != S_DONE) & ~mis;

    // Never let forwarding or WB see a write until the load data is real.
    assign rf_we_out = rf_we_r & ~pending & ~(is_mem & mis) & ~tmo_r;
    assign rf_wdata  = is_load ? al_load_val : result_r;

    assign mem_to_wb_bus = {pc_r, rf_we_out, waddr_r, rf_wdata};
    assign mem_to_rf_bus = {rf_we_out, waddr_r, rf_wdata};
    assign mem_excp      = {tmo_r, is_mem & mis};
    assign dbg_state     = state;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs.
module tb_mem_stage_hs;
    import mem_pkg::*;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic [5:0]  ctl_stall;
    logic [31:0] ex_pc;
    logic [2:0]  ex_mem_op;
    logic [1:0]  ex_st_size;
    logic [31:0] ex_addr;
    logic [31:0] ex_st_data;
    logic        ex_rf_we;
    logic [4:0]  ex_rf_waddr;
    logic [31:0] ex_result;
    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [3:0]  data_wen;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        stallreq_for_mem;
    logic [69:0] mem_to_wb_bus;
    logic [37:0] mem_to_rf_bus;
    logic [1:0]  mem_excp;
    logic [1:0]  dbg_state;

    int vectors;
    int miscompares;
    int nstall;

    // The controller stops stages 0..4 whenever MEM asks for a stall.
    assign stall = stallreq_for_mem ? 6'b011111 : ctl_stall;

    mem_stage_hs dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .ex_pc            (ex_pc),
        .ex_mem_op        (ex_mem_op),
        .ex_st_size       (ex_st_size),
        .ex_addr          (ex_addr),
        .ex_st_data       (ex_st_data),
        .ex_rf_we         (ex_rf_we),
        .ex_rf_waddr      (ex_rf_waddr),
        .ex_result        (ex_result),
        .data_req         (data_req),
        .data_we          (data_we),
        .data_addr        (data_addr),
        .data_wen         (data_wen),
        .data_wdata       (data_wdata),
        .data_gnt         (data_gnt),
        .data_rvalid      (data_rvalid),
        .data_rdata       (data_rdata),
        .stallreq_for_mem (stallreq_for_mem),
        .mem_to_wb_bus    (mem_to_wb_bus),
        .mem_to_rf_bus    (mem_to_rf_bus),
        .mem_excp         (mem_excp),
        .dbg_state        (dbg_state)
    );

    // Clock and tick.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one instruction from EX; it sits in MEM after the tick.
    task automatic issue(input logic [2:0] op, input logic [1:0] sz, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic we, input logic [4:0] wa,
                         input logic [31:0] res, input logic [31:0] pc);
        ex_mem_op   = op;
        ex_st_size  = sz;
        ex_addr     = addr;
        ex_st_data  = sdata;
        ex_rf_we    = we;
        ex_rf_waddr = wa;
        ex_result   = res;
        ex_pc       = pc;
        tick();
        ex_mem_op   = 3'd0;
        ex_st_size  = 2'd0;
        ex_addr     = 32'h0;
        ex_st_data  = 32'h0;
        ex_rf_we    = 1'b0;
        ex_rf_waddr = 5'h0;
        ex_result   = 32'h0;
        ex_pc       = 32'h0;
    endtask

    // Memory responder: grant at cycle gnt_dly, read data rv_dly cycles after
    // grant (rv_dly<0: never). Counts cycles with stall requested.
    task automatic run_access(input int gnt_dly, input int rv_dly, input logic [31:0] rd,
                              output int ns);
        int t;
        t  = 0;
        ns = 0;
        while (stallreq_for_mem && t < 40) begin
            data_gnt    = (t == gnt_dly);
            data_rvalid = (rv_dly >= 0) && (t == gnt_dly + rv_dly);
            data_rdata  = data_rvalid ? rd : $urandom;
            ns++;
            tick();
            t++;
        end
        data_gnt    = 1'b0;
        data_rvalid = 1'b0;
        data_rdata  = 32'h0;
        check("access_bound", 70'(t < 40), 70'(1));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        ctl_stall   = 6'b0;
        data_gnt    = 1'b0;
        data_rvalid = 1'b0;
        data_rdata  = 32'h0;
        ex_mem_op   = 3'd0;
        ex_st_size  = 2'd0;
        ex_addr     = 32'h0;
        ex_st_data  = 32'h0;
        ex_rf_we    = 1'b0;
        ex_rf_waddr = 5'h0;
        ex_result   = 32'h0;
        ex_pc       = 32'h0;
        rst         = 1'b1;
        tick();
        tick();

        // Reset state.
        check("rst_req", 70'(data_req), 70'(0));
        check("rst_wen", 70'(data_wen), 70'(0));
        check("rst_excp", 70'(mem_excp), 70'(0));
        check("rst_stall", 70'(stallreq_for_mem), 70'(0));
        check("rst_wb", mem_to_wb_bus, 70'(0));
        check("rst_rf", 70'(mem_to_rf_bus), 70'(0));
        check("rst_state", 70'(dbg_state), 70'(S_IDLE));
        rst = 1'b0;
        tick();

        // Non-memory op passes the ALU result straight through.
        issue(OP_NONE, 2'd0, 32'h0, 32'h0, 1'b1, 5'd7, 32'h11223344, 32'h500);
        check("alu_wb", mem_to_wb_bus, {32'h500, 1'b1, 5'd7, 32'h11223344});
        check("alu_stall", 70'(stallreq_for_mem), 70'(0));
        check("alu_req", 70'(data_req), 70'(0));

        // LW 0x100: grant at once, data three cycles later.
        issue(OP_LW, 2'd0, 32'h100, 32'h0, 1'b1, 5'd5, 32'h0, 32'h400);
        check("lw_req", 70'(data_req), 70'(1));
        check("lw_we", 70'(data_we), 70'(0));
        check("lw_addr", 70'(data_addr), 70'(32'h100));
        check("lw_fwd_gated", 70'(mem_to_rf_bus[37]), 70'(0));
        run_access(0, 3, 32'hDEADBEEF, nstall);
        check("lw_nstall", 70'(nstall), 70'(4));
        check("lw_wb", mem_to_wb_bus, {32'h400, 1'b1, 5'd5, 32'hDEADBEEF});
        check("lw_rf", 70'(mem_to_rf_bus), 70'({1'b1, 5'd5, 32'hDEADBEEF}));
        check("lw_state", 70'(dbg_state), 70'(S_DONE));
        check("lw_excp", 70'(mem_excp), 70'(0));
        tick();

        // Byte/half lane select and extension.
        issue(OP_LB, 2'd0, 32'h103, 32'h0, 1'b1, 5'd1, 32'h0, 32'h404);
        check("lb_addr", 70'(data_addr), 70'(32'h100));
        run_access(0, 1, 32'h80FF0000, nstall);
        check("lb_nstall", 70'(nstall), 70'(2));
        check("lb_data", 70'(mem_to_rf_bus), 70'({1'b1, 5'd1, 32'hFFFFFF80}));
        tick();
        issue(OP_LBU, 2'd0, 32'h103, 32'h0, 1'b1, 5'd2, 32'h0, 32'h408);
        run_access(0, 0, 32'h80FF0000, nstall);
        check("lbu_same_cycle_nstall", 70'(nstall), 70'(1));
        check("lbu_data", 70'(mem_to_rf_bus), 70'({1'b1, 5'd2, 32'h00000080}));
        tick();
        issue(OP_LH, 2'd0, 32'h102, 32'h0, 1'b1, 5'd3, 32'h0, 32'h40C);
        run_access(1, 1, 32'h80FF0000, nstall);
        check("lh_nstall", 70'(nstall), 70'(3));
        check("lh_data", 70'(mem_to_rf_bus), 70'({1'b1, 5'd3, 32'hFFFF80FF}));
        tick();
        issue(OP_LHU, 2'd0, 32'h102, 32'h0, 1'b1, 5'd4, 32'h0, 32'h410);
        run_access(0, 2, 32'h80FF0000, nstall);
        check("lhu_data", 70'(mem_to_rf_bus), 70'({1'b1, 5'd4, 32'h000080FF}));
        tick();

        // SB 0x102 with grant withheld two cycles.
        issue(OP_ST, 2'd0, 32'h102, 32'h000000A5, 1'b0, 5'd0, 32'h0, 32'h414);
        for (int k = 0; k < 3; k++) begin
            check("sb_req", 70'(data_req), 70'(1));
            check("sb_we", 70'(data_we), 70'(1));
            check("sb_addr", 70'(data_addr), 70'(32'h100));
            check("sb_wen", 70'(data_wen), 70'(4'b0100));
            check("sb_wdata", 70'(data_wdata), 70'(32'hA5A5A5A5));
            check("sb_stall", 70'(stallreq_for_mem), 70'(1));
            data_gnt = (k == 2);
            tick();
        end
        data_gnt = 1'b0;
        check("sb_done_stall", 70'(stallreq_for_mem), 70'(0));
        check("sb_done_req", 70'(data_req), 70'(0));
        check("sb_state", 70'(dbg_state), 70'(S_DONE));
        check("sb_rf_we", 70'(mem_to_rf_bus[37]), 70'(0));
        tick();

        // SH and SW strobes/data.
        issue(OP_ST, 2'd1, 32'h102, 32'hFFFF1234, 1'b0, 5'd0, 32'h0, 32'h418);
        check("sh_wen", 70'(data_wen), 70'(4'b1100));
        check("sh_wdata", 70'(data_wdata), 70'(32'h12341234));
        run_access(0, -1, 32'h0, nstall);
        check("sh_nstall", 70'(nstall), 70'(1));
        tick();
        issue(OP_ST, 2'd2, 32'h104, 32'h01020304, 1'b0, 5'd0, 32'h0, 32'h41C);
        check("sw_wen", 70'(data_wen), 70'(4'b1111));
        check("sw_wdata", 70'(data_wdata), 70'(32'h01020304));
        check("sw_addr", 70'(data_addr), 70'(32'h104));
        run_access(2, -1, 32'h0, nstall);
        check("sw_nstall", 70'(nstall), 70'(3));
        tick();

        // Misaligned LH: never issues.
        issue(OP_LH, 2'd0, 32'h101, 32'h0, 1'b1, 5'd9, 32'h0, 32'h420);
        check("mis_req", 70'(data_req), 70'(0));
        check("mis_excp", 70'(mem_excp), 70'(2'b01));
        check("mis_rf_we", 70'(mem_to_rf_bus[37]), 70'(0));
        check("mis_stall", 70'(stallreq_for_mem), 70'(0));
        tick();

        // LW timeout: 1 request cycle + 16 WAIT cycles, then a late rvalid.
        issue(OP_LW, 2'd0, 32'h200, 32'h0, 1'b1, 5'd6, 32'h0, 32'h424);
        run_access(0, -1, 32'h0, nstall);
        ctl_stall = 6'b011111;
        check("tmo_nstall", 70'(nstall), 70'(17));
        check("tmo_excp", 70'(mem_excp), 70'(2'b10));
        check("tmo_rf_we", 70'(mem_to_rf_bus[37]), 70'(0));
        check("tmo_state", 70'(dbg_state), 70'(S_DONE));
        data_rvalid = 1'b1;
        data_rdata  = 32'h12345678;
        tick();
        data_rvalid = 1'b0;
        data_rdata  = 32'h0;
        check("late_rv_state", 70'(dbg_state), 70'(S_DONE));
        check("late_rv_data", 70'(mem_to_rf_bus), 70'({1'b0, 5'd6, 32'h80FF0000}));
        check("late_rv_excp", 70'(mem_excp), 70'(2'b10));
        ctl_stall = 6'b0;
        tick();

        // Reset while in WAIT; the stale response afterwards is dropped.
        issue(OP_LW, 2'd0, 32'h300, 32'h0, 1'b1, 5'd8, 32'h0, 32'h428);
        data_gnt = 1'b1;
        tick();
        data_gnt = 1'b0;
        tick();
        check("wait_state", 70'(dbg_state), 70'(S_WAIT));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstw_req", 70'(data_req), 70'(0));
        check("rstw_state", 70'(dbg_state), 70'(S_IDLE));
        data_rvalid = 1'b1;
        data_rdata  = 32'hCAFEF00D;
        tick();
        data_rvalid = 1'b0;
        data_rdata  = 32'h0;
        check("rstw_wb", mem_to_wb_bus, 70'(0));
        check("rstw_rf", 70'(mem_to_rf_bus), 70'(0));
        check("rstw_excp", 70'(mem_excp), 70'(0));
        check("rstw_stall", 70'(stallreq_for_mem), 70'(0));
        check("rstw_state2", 70'(dbg_state), 70'(S_IDLE));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
